dpram_stream_reader: RTL and testbench

//  Drains one waveform readout DPRAM after the waveform buffer reader fills it.

---
 rtl/dpram_stream_reader.sv | 143 ++++++++++++++
 tb/tb_dpram_stream_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Drains a filled waveform readout DPRAM as a 16-bit valid/ready stream, 8 words per 128-bit line,
// and holds dpram_busy until the last word is accepted.
module dpram_stream_reader #(
  parameter int unsigned P_DPRAM_ADR_WIDTH = 8,
  parameter int unsigned P_LEN_WIDTH       = 16,
  parameter int unsigned P_RD_LATENCY      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         dpram_run_i,
  input  logic [P_LEN_WIDTH-1:0]       dpram_len_i,
  output logic                         dpram_busy_o,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr_o,
  input  logic [127:0]                 dpram_rd_data_i,
  output logic [15:0]                  out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o,
  output logic                         xfer_done_o,
  output logic                         len_err_o
);

  localparam int unsigned            Cap      = 8 * (2 ** P_DPRAM_ADR_WIDTH);
  localparam logic [P_LEN_WIDTH-1:0] CapLen   = P_LEN_WIDTH'(Cap);
  localparam logic [1:0]             WaitLast = 2'(P_RD_LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StDone} state_e;

  state_e                       state_q, state_d;
  logic [P_DPRAM_ADR_WIDTH-1:0] line_q, line_d;
  logic [P_LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic [P_LEN_WIDTH-1:0]       len_q, len_d;
  logic [1:0]                   wait_q, wait_d;
  logic [127:0]                 shreg_q, shreg_d;
  logic                         busy_q, busy_d;
  logic                         len_err_q, len_err_d;
  logic                         handshake;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      line_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wait_q    <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wait_q    <= wait_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wait_d    = wait_q;
    shreg_d   = shreg_q;
    busy_d    = busy_q;
    len_err_d = len_err_q;
    if (!en_i) begin
      state_d   = StIdle;
      line_d    = '0;
      cnt_d     = '0;
      len_d     = '0;
      wait_d    = '0;
      shreg_d   = '0;
      busy_d    = 1'b0;
      len_err_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dpram_run_i) begin
            busy_d = 1'b1;
            line_d = '0;
            cnt_d  = '0;
            wait_d = '0;
            if (32'(dpram_len_i) > Cap) begin
              len_d     = CapLen;
              len_err_d = 1'b1;
            end else begin
              len_d = dpram_len_i;
            end
            // Zero-length run still owns the DPRAM for one cycle so the reader sees a busy pulse.
            state_d = (dpram_len_i == '0) ? StDone : StFetch;
          end
        end
        StFetch: begin
          wait_d  = '0;
          state_d = StWait;
        end
        StWait: begin
          if (wait_q == WaitLast) begin
            shreg_d = dpram_rd_data_i;
            state_d = StSend;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
        StSend: begin
          if (handshake) begin
            shreg_d = {16'h0000, shreg_q[127:16]};
            cnt_d   = cnt_q + P_LEN_WIDTH'(1);
            if (cnt_d == len_q) begin
              busy_d  = 1'b0;
              state_d = StDone;
            end else if (cnt_q[2:0] == 3'd7) begin
              line_d  = line_q + P_DPRAM_ADR_WIDTH'(1);
              state_d = StFetch;
            end
          end
        end
        StDone: begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid_o     = (state_q == StSend);
    out_last_o      = out_valid_o && (cnt_q == len_q - P_LEN_WIDTH'(1));
    out_data_o      = shreg_q[15:0];
    xfer_done_o     = (state_q == StDone);
    dpram_busy_o    = busy_q;
    dpram_rd_addr_o = line_q;
    len_err_o       = len_err_q;
    handshake       = out_valid_o && out_ready_i;
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench for dpram_stream_reader: stimulus queues expected words, a negedge monitor
// pops and compares every accepted word and checks stall stability and busy release.
module tb_dpram_stream_reader;

  localparam int unsigned Cap = 2048;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         en_i = 1'b0;
  logic         dpram_run_i = 1'b0;
  logic [15:0]  dpram_len_i = '0;
  logic         dpram_busy_o;
  logic [7:0]   dpram_rd_addr_o;
  logic [127:0] dpram_rd_data_i;
  logic [15:0]  out_data_o;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic         out_last_o;
  logic         xfer_done_o;
  logic         len_err_o;

  logic [127:0] mem [256];
  logic [127:0] rd_p1, rd_p2;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   acc_cnt = 0, done_cnt = 0, busy_cyc = 0, valid_cyc = 0;
  int   ready_mode = 0;
  logic chk_fall = 1'b0, prev_stall = 1'b0, prev_l = 1'b0;
  logic [15:0] prev_d = '0;

  dpram_stream_reader #(
    .P_DPRAM_ADR_WIDTH(8),
    .P_LEN_WIDTH      (16),
    .P_RD_LATENCY     (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .dpram_run_i    (dpram_run_i),
    .dpram_len_i    (dpram_len_i),
    .dpram_busy_o   (dpram_busy_o),
    .dpram_rd_addr_o(dpram_rd_addr_o),
    .dpram_rd_data_i(dpram_rd_data_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_last_o     (out_last_o),
    .xfer_done_o    (xfer_done_o),
    .len_err_o      (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Two-stage read pipeline matching P_RD_LATENCY = 2; word n of the whole DPRAM holds value n.
  always @(posedge clk_i) begin
    rd_p1 <= mem[dpram_rd_addr_o];
    rd_p2 <= rd_p1;
  end
  assign dpram_rd_data_i = rd_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    #1;
    case (ready_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      default: out_ready_i = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk_i);
    if (dpram_busy_o) busy_cyc++;
    if (out_valid_o) valid_cyc++;
    if (xfer_done_o) done_cnt++;
    if (chk_fall) begin
      check("busy_fall_after_last", {31'd0, dpram_busy_o}, 32'd0);
      check("done_after_last", {31'd0, xfer_done_o}, 32'd1);
      chk_fall = 1'b0;
    end
    if (prev_stall && rst_ni && en_i) begin
      check("stall_valid_held", {31'd0, out_valid_o}, 32'd1);
      check("stall_data_stable", {16'd0, out_data_o}, {16'd0, prev_d});
      check("stall_last_stable", {31'd0, out_last_o}, {31'd0, prev_l});
    end
    if (out_valid_o && out_ready_i && rst_ni && en_i) begin
      if (exp_q.size() == 0) begin
        check("extra_word_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_data", {16'd0, out_data_o}, {16'd0, e.d});
        check("word_last", {31'd0, out_last_o}, {31'd0, e.l});
        if (e.l) chk_fall = 1'b1;
      end
      acc_cnt++;
    end
    prev_stall = out_valid_o && !out_ready_i && rst_ni && en_i;
    prev_d     = out_data_o;
    prev_l     = out_last_o;
  end

  task automatic start(input int len, input bit push);
    int n;
    n = (len > int'(Cap)) ? int'(Cap) : len;
    @(posedge clk_i);
    #1;
    if (push) begin
      for (int i = 0; i < n; i++) exp_q.push_back('{d: 16'(i), l: (i == n - 1)});
    end
    dpram_run_i = 1'b1;
    dpram_len_i = 16'(len);
    @(posedge clk_i);
    #1;
    dpram_run_i = 1'b0;
  endtask

  task automatic finish_xfer(input string name, input int d0, input int budget);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    repeat (4) @(posedge clk_i);
    #2;
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_idle"}, {31'd0, dpram_busy_o}, 32'd0);
  endtask

  task automatic xfer(input string name, input int len, input int budget);
    int d0;
    d0 = done_cnt;
    start(len, 1'b1);
    finish_xfer(name, d0, budget);
  endtask

  initial begin
    int d0, a0, k;
    for (int i = 0; i < 256; i++)
      for (int w = 0; w < 8; w++) mem[i][16*w +: 16] = 16'(i * 8 + w);

    repeat (3) @(posedge clk_i);
    #2;
    check("rst_busy", {31'd0, dpram_busy_o}, 32'd0);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_done", {31'd0, xfer_done_o}, 32'd0);
    check("rst_len_err", {31'd0, len_err_o}, 32'd0);
    check("rst_addr", {24'd0, dpram_rd_addr_o}, 32'd0);
    check("rst_data", {16'd0, out_data_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    en_i = 1'b1;

    xfer("t1_len8", 8, 200);
    xfer("t2_len11", 11, 200);
    ready_mode = 1;
    xfer("t3_len16_stall", 16, 400);
    ready_mode = 0;

    busy_cyc  = 0;
    valid_cyc = 0;
    xfer("t4_len0", 0, 50);
    check("t4_busy_cycles", 32'(busy_cyc), 32'd1);
    check("t4_no_valid", 32'(valid_cyc), 32'd0);

    d0 = done_cnt;
    a0 = acc_cnt;
    start(3000, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    dpram_run_i = 1'b1;
    dpram_len_i = 16'd5;
    @(posedge clk_i);
    #1;
    dpram_run_i = 1'b0;
    finish_xfer("t5_len3000", d0, 6000);
    check("t5_word_count", 32'(acc_cnt - a0), 32'd2048);
    check("t5_len_err_set", {31'd0, len_err_o}, 32'd1);
    en_i = 1'b0;
    @(posedge clk_i);
    #2;
    check("t5_len_err_cleared", {31'd0, len_err_o}, 32'd0);
    en_i = 1'b1;

    d0 = done_cnt;
    a0 = acc_cnt;
    start(8, 1'b1);
    k = 0;
    while (acc_cnt < a0 + 4 && k < 100) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    ready_mode  = 2;
    out_ready_i = 1'b0;
    en_i        = 1'b0;
    check("t6_words_before_abort", 32'(acc_cnt - a0), 32'd4);
    @(posedge clk_i);
    #2;
    check("t6_abort_busy", {31'd0, dpram_busy_o}, 32'd0);
    check("t6_abort_valid", {31'd0, out_valid_o}, 32'd0);
    repeat (4) @(posedge clk_i);
    #2;
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    en_i       = 1'b1;
    ready_mode = 0;
    xfer("t6_rerun", 8, 200);

    d0 = done_cnt;
    a0 = acc_cnt;
    start(16, 1'b1);
    k = 0;
    while (acc_cnt < a0 + 10 && k < 200) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    #3;
    rst_ni = 1'b0;
    #1;
    check("t7_rst_busy", {31'd0, dpram_busy_o}, 32'd0);
    check("t7_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("t7_rst_last", {31'd0, out_last_o}, 32'd0);
    check("t7_rst_addr", {24'd0, dpram_rd_addr_o}, 32'd0);
    check("t7_rst_data", {16'd0, out_data_o}, 32'd0);
    check("t7_rst_done", {31'd0, xfer_done_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    xfer("t7_after_reset", 5, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
